// File: rtl/bca_pkg.sv
// Shared definitions for the bit_carry_adder: default operand width,
// lookahead group size, and the operand vector type.
package bca_pkg;

  localparam int BCA_WIDTH = 16;
  localparam int BCA_GROUP = 4;

  typedef logic [BCA_WIDTH-1:0] bca_operand_t;

endpackage : bca_pkg

// File: rtl/bit_carry_adder_cla4.sv
// cla4: 4-bit carry-lookahead group. Produces the group sum from its carry-in
// and exports group propagate/generate for the second-level lookahead unit.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Per-bit generate/propagate and flattened in-group carries (no ripple).
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
    pg   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule : cla4

// File: rtl/bit_carry_adder.sv
// bit_carry_adder: registered two-level carry-lookahead adder,
// {cout,sum} = a + b + cin with one cycle of latency.
// Optional feature: define BCA_OVERFLOW_EN to add the registered signed
// overflow output ovf.
// WIDTH must be a multiple of 4 and at least 4.
import bca_pkg::*;

module bit_carry_adder #(
  parameter int WIDTH = BCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             cout,
  output logic [WIDTH-1:0] sum,
  input  logic             in_valid,
  output logic             out_valid
`ifdef BCA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = WIDTH / BCA_GROUP;

  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;

  // One lookahead group per nibble; each receives its carry from the second level.
  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      cla4 u_cla4 (
        .a  (a[gi*BCA_GROUP +: BCA_GROUP]),
        .b  (b[gi*BCA_GROUP +: BCA_GROUP]),
        .ci (grp_c[gi]),
        .s  (sum_next[gi*BCA_GROUP +: BCA_GROUP]),
        .pg (grp_p[gi]),
        .gg (grp_g[gi])
      );
    end
  endgenerate

  // Second-level lookahead: every group carry is a flat sum of products of
  // cin and the group P/G terms, so no carry waits on a lower group's carry.
  always_comb begin
    logic carry;
    logic term;
    grp_c    = '0;
    carry    = 1'b0;
    term     = 1'b0;
    grp_c[0] = cin;
    for (int k = 1; k <= NG; k++) begin
      carry = cin;
      for (int j = 0; j < k; j++) begin
        carry = carry & grp_p[j];
      end
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        carry = carry | term;
      end
      grp_c[k] = carry;
    end
    cout_next = grp_c[NG];
  end

  // Valid flag: in_valid delayed by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  // Result registers: load on valid operands, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (in_valid) begin
      sum  <= sum_next;
      cout <= cout_next;
    end
  end

`ifdef BCA_OVERFLOW_EN
  logic msb_carry_in;
  logic ovf_next;

  // The carry into the MSB is recovered from the MSB sum bit and its propagate.
  always_comb begin
    msb_carry_in = sum_next[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
    ovf_next     = msb_carry_in ^ cout_next;
  end

  // Overflow register follows the same load/hold rules as sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= ovf_next;
    end
  end
`endif

endmodule : bit_carry_adder

// File: tb/tb_bit_carry_adder.sv
// Scoreboard testbench for bit_carry_adder: stimulus pushes hand-computed
// results into a queue, a negedge monitor pops and compares on out_valid and
// checks hold/reset values otherwise. Define BCA_OVERFLOW_EN to check ovf too.
`timescale 1ns/1ps
module tb_bit_carry_adder;
  import bca_pkg::*;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  bca_operand_t a;
  bca_operand_t b;
  logic         cin;
  logic         cout;
  bca_operand_t sum;
  logic         in_valid;
  logic         out_valid;
`ifdef BCA_OVERFLOW_EN
  logic         ovf;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pops   = 0;
  int   pushes = 0;
  exp_t sb[$];

  logic [15:0] held_sum;
  logic        held_cout;
  logic        held_ovf;

  vec_t vecs[15];

  bit_carry_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .cout      (cout),
    .sum       (sum),
    .in_valid  (in_valid),
    .out_valid (out_valid)
`ifdef BCA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one valid operand set and push its expected result.
  task automatic send(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    in_valid = 1'b1;
    e.sum    = v.sum;
    e.cout   = v.cout;
    e.ovf    = v.ovf;
    e.cyc    = cyc + 1;
    sb.push_back(e);
    pushes++;
    $display("issue a=%04h b=%04h cin=%0d -> exp sum=%04h cout=%0d ovf=%0d",
             v.a, v.b, v.cin, v.sum, v.cout, v.ovf);
  endtask

  // Idle cycle with scrambled operands so a missing hold shows up.
  task automatic idle();
    @(posedge clk);
    #1;
    a        = 16'h3C5A;
    b        = 16'hE71B;
    cin      = 1'b1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare on out_valid, otherwise check held or reset values.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_sum", 32'(sum), 32'h0);
      chk("rst_cout", 32'(cout), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      held_sum  = 16'h0;
      held_cout = 1'b0;
      held_ovf  = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        pops++;
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
`ifdef BCA_OVERFLOW_EN
        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
        $display("result sum=%04h cout=%0d exp sum=%04h cout=%0d", sum, cout, e.sum, e.cout);
        held_sum  = e.sum;
        held_cout = e.cout;
        held_ovf  = e.ovf;
      end
    end else begin
      chk("hold_sum", 32'(sum), 32'(held_sum));
      chk("hold_cout", 32'(cout), 32'(held_cout));
`ifdef BCA_OVERFLOW_EN
      chk("hold_ovf", 32'(ovf), 32'(held_ovf));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            a        b        cin   sum      cout  ovf
    vecs[0]  = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFE, 16'h0006, 1'b0, 16'h0004, 1'b1, 1'b0};
    vecs[2]  = '{16'h0ABF, 16'h96D5, 1'b1, 16'hA195, 1'b0, 1'b0};
    vecs[3]  = '{16'h81C3, 16'h9FFC, 1'b0, 16'h21BF, 1'b1, 1'b1};
    vecs[4]  = '{16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{16'h1C71, 16'h2706, 1'b1, 16'h4378, 1'b0, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[9]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[10] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[11] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    vecs[12] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[13] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
    vecs[14] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};

    held_sum  = 16'h0;
    held_cout = 1'b0;
    held_ovf  = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle();

    // Back-to-back stream including the consecutive 0x00FF/0x1C71 pair.
    for (int i = 0; i <= 5; i++) send(vecs[i]);
    idle();
    idle();
    // Boundary and overflow vectors with idle gaps between some of them.
    for (int i = 6; i <= 13; i++) begin
      send(vecs[i]);
      if (i % 3 == 0) idle();
    end
    idle();
    idle();

    // Asynchronous reset between edges while a result is present.
    send(vecs[14]);
    @(posedge clk);
    #1;
    chk("pre_reset_out_valid", 32'(out_valid), 32'h1);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_rst_sum", 32'(sum), 32'h0);
    chk("async_rst_cout", 32'(cout), 32'h0);
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    sb.delete();
    pushes--;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    idle();
    send(vecs[3]);
    send(vecs[9]);
    idle();
    idle();
    idle();

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    chk("result_count", 32'(pops), 32'(pushes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bit_carry_adder
